line_fill_wb_ctrl: RTL and testbench
====================================

Name: line_fill_wb_ctrl

Overview:
- Cache-side memory request controller, directly upstream of the 512-bit line memory slave.
- Accepts line-fill (read) requests and victim writebacks from the cache controller.
- Buffers writebacks in a small FIFO and serialises all traffic onto the single-outstanding valid/rw/addr/ready memory bus.
- Forwards fill data straight from the writeback buffer on an address hit, so stale memory is never read.

Parameters:
- WB_DEPTH, 2: writeback buffer entries (power of 2, ≥2).
- TIMEOUT_CYCLES, 255: memory wait cycles before the timeout flag sets.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- fill_req  in  1  fill request; held high until fill_done.
- fill_addr  in  ADDR_W  fill byte address; stable while fill_req.
- fill_done  out  1  one-cycle pulse; fill_data valid.
- fill_data  out  512  returned line, word0 = [63:0].
- wb_valid  in  1  writeback push strobe.
- wb_addr  in  ADDR_W  victim byte address.
- wb_data  in  512  victim line.
- wb_ready  out  1  buffer not full.
- mem_valid  out  1  request strobe, exactly one cycle per transaction.
- mem_rw  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  line address, bits [5:0] forced 0.
- mem_wr_data  out  512  write line.
- mem_rd_data  in  512  read line, valid when mem_ready.
- mem_ready  in  1  transaction complete, one-cycle pulse.
- busy  out  1  state != IDLE or buffer non-empty.
- timeout_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst low at clk edge):
  - All outputs 0, except wb_ready = 1.
  - Buffer emptied; state IDLE; timeout counter cleared.
  - Applies mid-transaction. An outstanding memory access is abandoned with no completion.
- Push: on wb_valid && wb_ready, {wb_addr[31:6], wb_data} is written to the FIFO tail.
  - wb_valid while full is ignored; the cache must hold it.
  - wb_ready = count < WB_DEPTH, registered-count based.
- Line match compares addr[31:6] only.
- States: IDLE, FWD, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT.
- IDLE priority, evaluated each cycle:
  - (1) fill_req and hit → FWD. A hit is a buffer entry match or a same-cycle accepted push match. The youngest match wins; a same-cycle push is youngest.
  - (2) fill_req and no hit and buffer not full → RD_ISSUE.
  - (3) buffer non-empty → WR_ISSUE.
  - else stay.
  - A full buffer drains before a missing fill is served.
- FWD: fill_done = 1 for one cycle with the matched data; → IDLE. Zero memory traffic.
- RD_ISSUE: mem_valid = 1, mem_rw = 0, mem_addr = {fill_addr[31:6], 6'b0}; next cycle → RD_WAIT.
- RD_WAIT: on mem_ready, register mem_rd_data into fill_data and pulse fill_done on the following cycle, then → IDLE.
  - Fill latency from mem_ready to fill_done is 1 cycle.
- WR_ISSUE: mem_valid = 1, mem_rw = 1, mem_addr/mem_wr_data from the FIFO head; → WR_WAIT.
- WR_WAIT: on mem_ready, pop the head and → IDLE.
  - The head entry stays forwardable until it is popped.
- mem_addr, mem_rw and mem_wr_data hold their values from ISSUE until mem_ready.
- mem_valid is never high in consecutive cycles, and never high while waiting.
- Timeout: the counter increments each cycle in RD_WAIT/WR_WAIT and clears on entering ISSUE.
  - At TIMEOUT_CYCLES, timeout_err sets and stays set until reset.
  - The FSM keeps waiting and does not abandon the transaction.
- mem_ready outside WAIT states is ignored.
- Pushes are accepted in every state, including during WR_WAIT.
  - The pop and a push in the same cycle leave count unchanged.
- Pointers wrap modulo WB_DEPTH.

Test Plan:
- Reset, then fill_req addr 0x0000_1040 with no pushes → one mem_valid pulse (rw=0, addr 0x0000_1040); memory returns line pattern 0x11..; fill_done one cycle after mem_ready with the same data; busy returns to 0.
- Push wb addr 0x200 data A, then fill_req addr 0x23F → fill_done via FWD with data A; no mem_valid asserted.
- Push 0x400/B and 0x440/C (full, wb_ready=0), then fill_req 0x800 → writes of B then C issued in FIFO order; fill read issued only after the first pop; wb_ready rises on the first pop.
- Same-cycle wb_valid 0x600/D and fill_req 0x600 in IDLE → FWD returns D; D is later written to memory.
- Withhold mem_ready with TIMEOUT_CYCLES=8 → timeout_err rises after 8 wait cycles; a late mem_ready still completes the fill; timeout_err stays 1.
- Assert rst low during RD_WAIT → next cycle all outputs 0, wb_ready=1, buffer empty; a subsequent fill operates normally.

Source files
------------

// File: rtl/line_fill_wb_ctrl.sv
// Cache-side memory request controller: serialises line fills and buffered victim
// writebacks onto a single-outstanding memory bus, forwarding fills from the buffer on a hit.
module line_fill_wb_ctrl #(
   parameter int WB_DEPTH       = 2,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fill_req,
   input  logic [ADDR_W-1:0] fill_addr,
   output logic              fill_done,
   output logic [511:0]      fill_data,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [511:0]      wb_data,
   output logic              wb_ready,
   output logic              mem_valid,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [511:0]      mem_wr_data,
   input  logic [511:0]      mem_rd_data,
   input  logic              mem_ready,
   output logic              busy,
   output logic              timeout_err
);
   localparam int PTR_W  = $clog2(WB_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int LINE_W = ADDR_W - 6;
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WB_DEPTH);
   localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, FWD, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT} state_t;

   state_t              state_q;
   logic [LINE_W-1:0]   buf_addr_q [WB_DEPTH];
   logic [511:0]        buf_data_q [WB_DEPTH];
   logic [PTR_W-1:0]    head_q, tail_q;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [TO_W-1:0]     to_cnt_q;
   logic                fill_done_q, mem_valid_q, mem_rw_q, timeout_q;
   logic [511:0]        fill_data_q, mem_wr_data_q;
   logic [ADDR_W-1:0]   mem_addr_q;

   logic                push_acc, pop, full, fill_act, hit;
   logic [511:0]        hit_data;
   logic [LINE_W-1:0]   fill_line;
   logic                unused_lsbs;

   assign fill_line   = fill_addr[ADDR_W-1:6];
   assign full        = (count_q == DEPTH_C);
   assign push_acc    = wb_valid && !full;
   assign pop         = (state_q == WR_WAIT) && mem_ready;
   // The fill_done cycle still sees the old fill_req; it must not start a second fill.
   assign fill_act    = fill_req && !fill_done_q;
   assign unused_lsbs = ^{fill_addr[5:0], wb_addr[5:0]};

   // Oldest-to-youngest scan so the youngest match wins; a same-cycle push is youngest of all.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         if ((CNT_W'(i) < count_q) && (buf_addr_q[head_q + PTR_W'(i)] == fill_line)) begin
            hit      = 1'b1;
            hit_data = buf_data_q[head_q + PTR_W'(i)];
         end
      end
      if (push_acc && (wb_addr[ADDR_W-1:6] == fill_line)) begin
         hit      = 1'b1;
         hit_data = wb_data;
      end
   end

   always_comb begin
      count_d = count_q;
      if (push_acc && !pop)      count_d = count_q + 1'b1;
      else if (!push_acc && pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push_acc) begin
         buf_addr_q[tail_q] <= wb_addr[ADDR_W-1:6];
         buf_data_q[tail_q] <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_acc) tail_q <= tail_q + 1'b1;
         if (pop)      head_q <= head_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE;
         fill_done_q   <= 1'b0;
         fill_data_q   <= '0;
         mem_valid_q   <= 1'b0;
         mem_rw_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wr_data_q <= '0;
         to_cnt_q      <= '0;
         timeout_q     <= 1'b0;
      end else begin
         fill_done_q <= 1'b0;
         mem_valid_q <= 1'b0;
         if ((state_q == RD_WAIT) || (state_q == WR_WAIT)) begin
            if (to_cnt_q != TO_MAX)  to_cnt_q  <= to_cnt_q + 1'b1;
            if (to_cnt_q == TO_LAST) timeout_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (fill_act && hit) begin
                  fill_data_q <= hit_data;
                  fill_done_q <= 1'b1;
                  state_q     <= FWD;
               end else if (fill_act && !full) begin
                  mem_valid_q <= 1'b1;
                  mem_rw_q    <= 1'b0;
                  mem_addr_q  <= {fill_line, 6'b0};
                  to_cnt_q    <= '0;
                  state_q     <= RD_ISSUE;
               end else if (count_q != '0) begin
                  mem_valid_q   <= 1'b1;
                  mem_rw_q      <= 1'b1;
                  mem_addr_q    <= {buf_addr_q[head_q], 6'b0};
                  mem_wr_data_q <= buf_data_q[head_q];
                  to_cnt_q      <= '0;
                  state_q       <= WR_ISSUE;
               end
            end
            FWD:      state_q <= IDLE;
            RD_ISSUE: state_q <= RD_WAIT;
            RD_WAIT: begin
               if (mem_ready) begin
                  fill_data_q <= mem_rd_data;
                  fill_done_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            WR_ISSUE: state_q <= WR_WAIT;
            WR_WAIT: begin
               if (mem_ready) state_q <= IDLE;
            end
            default:  state_q <= IDLE;
         endcase
      end
   end

   assign fill_done   = fill_done_q;
   assign fill_data   = fill_data_q;
   assign wb_ready    = !full;
   assign mem_valid   = mem_valid_q;
   assign mem_rw      = mem_rw_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wr_data = mem_wr_data_q;
   assign busy        = (state_q != IDLE) || (count_q != '0);
   assign timeout_err = timeout_q;
endmodule

// File: tb/tb_line_fill_wb_ctrl.sv
// Bench for line_fill_wb_ctrl: directed scenarios plus random push/fill traffic against
// a line-granular memory model with an ordered writeback queue.
module tb_line_fill_wb_ctrl;
   logic          clk, rst;
   logic          fill_req, fill_done;
   logic [31:0]   fill_addr;
   logic [511:0]  fill_data;
   logic          wb_valid, wb_ready;
   logic [31:0]   wb_addr;
   logic [511:0]  wb_data;
   logic          mem_valid, mem_rw, mem_ready;
   logic [31:0]   mem_addr;
   logic [511:0]  mem_wr_data, mem_rd_data;
   logic          busy, timeout_err;

   line_fill_wb_ctrl #(.WB_DEPTH(2), .TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .fill_req(fill_req), .fill_addr(fill_addr), .fill_done(fill_done), .fill_data(fill_data),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
      .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data), .mem_ready(mem_ready),
      .busy(busy), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   typedef struct { logic [25:0] line; logic [511:0] data; } wb_t;
   wb_t          exp_q[$];
   logic [511:0] mem_m [logic [25:0]];
   logic [32:0]  log_q[$];
   int           nmem = 0;
   bit           resp_hold = 0;
   logic [25:0]  cur_fill_line = '0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] mem_rd(input logic [25:0] l);
      if (mem_m.exists(l)) return mem_m[l];
      return {16{{6'b0, l} ^ 32'hA5A5_5A5A}};
   endfunction

   // Newest buffered copy of a line if any, otherwise memory contents.
   function automatic logic [511:0] exp_fill(input logic [25:0] l);
      logic [511:0] r;
      r = mem_rd(l);
      foreach (exp_q[i]) if (exp_q[i].line == l) r = exp_q[i].data;
      return r;
   endfunction

   function automatic bit in_queue(input logic [25:0] l);
      foreach (exp_q[i]) if (exp_q[i].line == l) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [511:0] rand_line();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Memory slave: random latency, optional hold, abandons on reset.
   initial begin
      mem_ready   = 1'b0;
      mem_rd_data = '0;
      forever begin
         @(negedge clk);
         if (rst && mem_valid) begin
            logic         rw_s, ab;
            logic [31:0]  a_s;
            logic [511:0] wd_s;
            int           d;
            rw_s = mem_rw; a_s = mem_addr; wd_s = mem_wr_data;
            nmem++;
            log_q.push_back({rw_s, a_s});
            chk("mem_addr_lsb", a_s[5:0], 6'd0);
            if (rw_s) begin
               if (exp_q.size() == 0) chk("wr_nothing_buffered", 1, 0);
               else begin
                  chk("wr_head_addr", a_s, {exp_q[0].line, 6'b0});
                  chk("wr_head_data", wd_s, exp_q[0].data);
               end
            end else begin
               chk("rd_addr", a_s, {cur_fill_line, 6'b0});
               chk("rd_of_buffered_line", in_queue(a_s[31:6]), 0);
            end
            d  = $urandom_range(1, 4);
            ab = 1'b0;
            for (int k = 0; (k < d || resp_hold) && k < 3000; k++) begin
               @(negedge clk);
               if (!rst) begin ab = 1'b1; break; end
               chk("mem_valid_while_wait", mem_valid, 0);
            end
            if (!ab) begin
               chk("mem_req_held", {mem_rw, mem_addr, mem_wr_data}, {rw_s, a_s, wd_s});
               mem_ready   = 1'b1;
               mem_rd_data = rw_s ? '0 : mem_rd(a_s[31:6]);
               @(posedge clk);
               if (rw_s) begin
                  mem_m[a_s[31:6]] = wd_s;
                  if (exp_q.size() != 0) void'(exp_q.pop_front());
               end
               @(negedge clk);
               mem_ready = 1'b0;
            end
         end
      end
   end

   task automatic push(input logic [31:0] a, input logic [511:0] d);
      wb_t e;
      wb_valid = 1'b1; wb_addr = a; wb_data = d;
      for (int i = 0; i < 400; i++) begin
         if (wb_ready) break;
         @(negedge clk);
      end
      if (!wb_ready) begin
         chk("push_accept_timeout", 0, 1);
         wb_valid = 1'b0;
      end else begin
         @(posedge clk);
         e.line = a[31:6]; e.data = d;
         exp_q.push_back(e);
         @(negedge clk);
         wb_valid = 1'b0;
      end
   endtask

   task automatic wait_fill(input string tag, input logic [31:0] a);
      bit got = 0;
      for (int i = 0; i < 400; i++) begin
         if (fill_done) begin got = 1; break; end
         @(negedge clk);
      end
      chk({tag, "_done"}, got, 1);
      if (got) chk({tag, "_data"}, fill_data, exp_fill(a[31:6]));
      fill_req = 1'b0;
      @(negedge clk);
      chk({tag, "_pulse"}, fill_done, 0);
   endtask

   task automatic do_fill(input string tag, input logic [31:0] a);
      cur_fill_line = a[31:6];
      fill_addr = a;
      fill_req  = 1'b1;
      wait_fill(tag, a);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 500; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      chk(tag, busy, 0);
   endtask

   task automatic wait_mem_valid(input string tag);
      bit got = 0;
      for (int i = 0; i < 50; i++) begin
         if (mem_valid) begin got = 1; break; end
         @(negedge clk);
      end
      chk(tag, got, 1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_fill_done"}, fill_done, 0);
      chk({tag, "_fill_data"}, fill_data, 0);
      chk({tag, "_wb_ready"}, wb_ready, 1);
      chk({tag, "_mem_valid"}, mem_valid, 0);
      chk({tag, "_mem_rw"}, mem_rw, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wr_data"}, mem_wr_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_timeout"}, timeout_err, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      logic [511:0] la, lb, lc, ld, le;
      logic [25:0]  ln;
      rst = 1'b0; fill_req = 1'b0; fill_addr = '0;
      wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst0");
      rst = 1'b1;
      @(negedge clk);

      // Plain miss served from memory
      mem_m[26'h41] = {64{8'h11}};
      n0 = nmem;
      do_fill("t1", 32'h0000_1040);
      chk("t1_mem_count", nmem - n0, 1);
      chk("t1_log", log_q[$], {1'b0, 32'h0000_1040});
      chk("t1_data_pattern", fill_data, {64{8'h11}});
      wait_idle("t1_idle");

      // Forward from the buffer, no memory read
      la = rand_line();
      push(32'h200, la);
      n0 = nmem;
      do_fill("t2", 32'h23F);
      chk("t2_mem_count", nmem - n0, 0);
      chk("t2_fwd_data", fill_data, la);
      wait_idle("t2_idle");
      chk("t2_written_back", mem_rd(26'h8), la);

      // Full buffer drains before the missing fill
      log_q.delete();
      lb = rand_line(); lc = rand_line();
      push(32'h400, lb);
      push(32'h440, lc);
      chk("t3_full_ready", wb_ready, 0);
      do_fill("t3", 32'h800);
      chk("t3_ready_after_pop", wb_ready, 1);
      wait_idle("t3_idle");
      chk("t3_log_size", log_q.size(), 3);
      if (log_q.size() == 3) begin
         chk("t3_log0", log_q[0], {1'b1, 32'h400});
         chk("t3_log1", log_q[1], {1'b0, 32'h800});
         chk("t3_log2", log_q[2], {1'b1, 32'h440});
      end

      // Same-cycle push and fill of one line
      ld = rand_line();
      n0 = nmem;
      cur_fill_line = 26'h18;
      wb_valid = 1'b1; wb_addr = 32'h600; wb_data = ld;
      fill_addr = 32'h600; fill_req = 1'b1;
      @(posedge clk);
      begin
         wb_t e;
         e.line = 26'h18; e.data = ld;
         exp_q.push_back(e);
      end
      @(negedge clk);
      wb_valid = 1'b0;
      wait_fill("t4", 32'h600);
      chk("t4_fwd_data", fill_data, ld);
      chk("t4_mem_count", nmem - n0, 0);
      wait_idle("t4_idle");
      chk("t4_written_back", mem_rd(26'h18), ld);

      // Timeout during a held read
      chk("t5_timeout_clear", timeout_err, 0);
      resp_hold = 1'b1;
      cur_fill_line = 26'hC0;
      fill_addr = 32'h3000; fill_req = 1'b1;
      wait_mem_valid("t5_issue");
      repeat (8) @(negedge clk);
      chk("t5_timeout_early", timeout_err, 0);
      @(negedge clk);
      chk("t5_timeout_set", timeout_err, 1);
      resp_hold = 1'b0;
      wait_fill("t5", 32'h3000);
      chk("t5_timeout_sticky", timeout_err, 1);
      wait_idle("t5_idle");

      // Reset in RD_WAIT with a buffered entry
      resp_hold = 1'b1;
      cur_fill_line = 26'h140;
      fill_addr = 32'h5000; fill_req = 1'b1;
      wait_mem_valid("t6_issue");
      @(negedge clk);
      le = rand_line();
      push(32'h700, le);
      rst = 1'b0; fill_req = 1'b0;
      @(negedge clk);
      chk_reset_outputs("t6_rst");
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1; resp_hold = 1'b0;
      @(negedge clk);
      n0 = nmem;
      do_fill("t6", 32'h700);
      chk("t6_mem_count", nmem - n0, 1);
      wait_idle("t6_idle");

      // Random traffic
      for (int it = 0; it < 120; it++) begin
         int op;
         op = $urandom_range(0, 3);
         ln = 26'h40 + 26'($urandom_range(0, 5));
         if (op <= 1) begin
            push({ln, 6'($urandom)}, rand_line());
            if ($urandom_range(0, 1) == 1) begin
               ln = 26'h40 + 26'($urandom_range(0, 5));
               do_fill("rnd_fill_after_push", {ln, 6'($urandom)});
            end
         end else if (op == 2) begin
            do_fill("rnd_fill", {ln, 6'($urandom)});
         end else begin
            repeat ($urandom_range(1, 5)) @(negedge clk);
         end
      end
      wait_idle("end_idle");
      chk("end_queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
